serial_addsub: RTL

Parametrised bit-serial adder/subtractor for the COA datapath. It latches two WIDTH-bit operands and processes one bit per clock, LSB first, through a single carry flip-flop. Results are a parallel sum, carry-out and signed overflow, plus a serial sum-bit stream. A start/busy/done handshake fronts the block so a controller FSM can issue back-to-back operations.

---
 rtl/serial_addsub.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub
// -----------------------------------------------------------------------------
// Bit-serial adder/subtractor. Two WIDTH-bit operands are latched on an
// accepted start and processed one bit per clock, LSB first, through a
// single carry flip-flop. Subtraction is a + ~b + ~c_in, so c_out = 1 means
// "no borrow".
//
// Handshake: start is sampled only in IDLE or DONE. busy is high while bits
// are processed. done is a one-cycle pulse in the cycle the result becomes
// valid. busy and done are never high together. Holding start high in DONE
// chains the next operation with no idle gap.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   start      operation request
//   sub        0 = add, 1 = subtract (sampled with start)
//   c_in       carry-in / borrow-in (sampled with start)
//   a, b       operands (sampled with start)
//   busy       high while bits are being processed
//   done       one-cycle result-valid pulse
//   sum        parallel result, held until the next accepted start
//   c_out      final carry (subtract: 1 = no borrow)
//   ovf        signed overflow
//   sum_bit    registered serial result bit from the latest RUN edge
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             sum_bit,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_sum_bit;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_cy;

  // A new operation can only be taken while no bits are in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

  // Full adder on the current LSBs.
  assign w_s  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cy = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_c_out   <= 1'b0;
      r_ovf     <= 1'b0;
      r_sum_bit <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= c_in ^ sub;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == S_RUN) begin
      r_a       <= r_a >> 1;
      r_b       <= r_b >> 1;
      r_carry   <= w_cy;
      r_res     <= {w_s, r_res[WIDTH-1:1]};
      r_cnt     <= r_cnt + 1'b1;
      r_sum_bit <= w_s;
      if (w_last) begin
        // On the MSB edge r_carry is the carry into the MSB and w_cy the
        // carry out of it; their XOR is signed overflow.
        r_sum   <= {w_s, r_res[WIDTH-1:1]};
        r_c_out <= w_cy;
        r_ovf   <= r_carry ^ w_cy;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign sum_bit   = r_sum_bit;
  assign dbg_state = r_state;

endmodule
